// File: rtl/button_conditioner.sv
// button_conditioner
// Multi-channel push-button / switch conditioner. Each channel has:
//   - an optional input inversion so "pressed" always reads as 1 internally,
//   - a SYNC_STAGES-deep synchroniser,
//   - a counter debouncer that accepts a new value only after it has been
//     seen for DEBOUNCE_CYCLES consecutive cycles,
//   - a registered edge pulse, with the edge direction chosen by EDGE_MODE,
//   - a hold-to-auto-repeat FSM producing a periodic one-cycle rpt pulse.
// All outputs are registered. Nothing combinational runs from sig to an output.
`timescale 1ns/1ps

module button_conditioner #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sig,
  output logic [N-1:0] level,
  output logic [N-1:0] pulse,
  output logic [N-1:0] rpt
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  // Hold counter must reach the larger of the delay and the period.
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] RD_COUNT = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] RP_COUNT = HW'(REPEAT_PERIOD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // Normalise polarity before synchronising so the rest of the logic
  // always treats 1 as "pressed".
  logic [N-1:0] w_sig_in;
  assign w_sig_in = (ACTIVE_LOW != 0) ? ~sig : sig;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_db_cnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   r_rpt;
    rpt_state_t             r_state;
    logic [HW-1:0]          r_hold_cnt;

    logic w_sync_out;
    logic w_accept;
    logic w_rise;
    logic w_fall;
    logic w_pulse_hit;

    assign w_sync_out  = r_sync[SYNC_STAGES-1];
    // The new value has persisted long enough on this cycle.
    assign w_accept    = (w_sync_out != r_level) && (r_db_cnt == DB_LAST);
    assign w_rise      = w_accept && !r_level;
    assign w_fall      = w_accept && r_level;
    // Mode 0 = rise only, 1 = fall only, 2 = both.
    assign w_pulse_hit = (w_rise && (EDGE_MODE != 1)) || (w_fall && (EDGE_MODE != 0));

    // Synchroniser chain, shifting toward the MSB.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_sig_in[gi]};
      end
    end

    // Debouncer: count consecutive disagreeing cycles, accept on the last one.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_db_cnt <= '0;
        r_level  <= 1'b0;
        r_pulse  <= 1'b0;
      end else begin
        r_pulse <= w_pulse_hit;
        if (w_sync_out == r_level) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_level  <= w_sync_out;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end

    // Auto-repeat FSM: initial delay after the rise, then a fixed period.
    // A falling level always wins and silences the channel immediately.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state    <= ST_IDLE;
        r_hold_cnt <= '0;
        r_rpt      <= 1'b0;
      end else begin
        r_rpt <= 1'b0;
        if (w_fall) begin
          r_state    <= ST_IDLE;
          r_hold_cnt <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_rise && (REPEAT_DELAY > 0)) begin
                r_state    <= ST_HOLD;
                r_hold_cnt <= HOLD_ONE;
              end
            end
            ST_HOLD: begin
              if (r_hold_cnt == RD_COUNT) begin
                r_rpt      <= 1'b1;
                r_hold_cnt <= HOLD_ONE;
                r_state    <= ST_REPEAT;
              end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (r_hold_cnt == RP_COUNT) begin
                r_rpt      <= 1'b1;
                r_hold_cnt <= HOLD_ONE;
              end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end
            default: begin
              r_state    <= ST_IDLE;
              r_hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign level[gi] = r_level;
    assign pulse[gi] = r_pulse;
    assign rpt[gi]   = r_rpt;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel input conditioner for the clock's push-buttons and switches. Each channel gets a synchroniser, a counter-based debouncer, configurable edge pulses and an optional hold-to-auto-repeat pulse train. It sits between the board pins and the time-set / mode control FSM. It replaces single-channel, rising-edge-only detection that has no debounce.

## Interface
Parameters:
- N, 4: number of independent channels.
- SYNC_STAGES, 2: synchroniser depth. Legal range is at least 2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a new value must persist before it is accepted. Legal range is at least 1.
- EDGE_MODE, 0: selects which `level` transitions produce `pulse`. 0 = rise only, 1 = fall only, 2 = both.
- ACTIVE_LOW, 0: when 1, `sig` is inverted before the synchroniser, so a pressed button reads as 1 internally.
- REPEAT_DELAY, 10: cycles from the accepted rise to the first `rpt`. 0 disables auto-repeat.
- REPEAT_PERIOD, 3: cycles between successive `rpt` pulses. Legal range is at least 1.

Ports:
- clk  in  1  system clock. All logic is on its rising edge.
- rst_n  in  1  synchronous reset, active low.
- sig  in  N  raw asynchronous inputs.
- level  out  N  debounced level of each channel.
- pulse  out  N  one-cycle edge pulse per channel.
- rpt  out  N  one-cycle auto-repeat pulse per channel.

## Operation
- Channels are fully independent. All per-channel state is replicated N times.
- **Synchroniser:** a SYNC_STAGES-deep flop chain per channel. It carries sig, or ~sig when ACTIVE_LOW=1.
- **Debouncer:** per-channel counter, width $clog2(DEBOUNCE_CYCLES+1).
  - When the synchroniser output equals `level`: counter is cleared to 0.
  - When it differs and counter < DEBOUNCE_CYCLES-1: counter increments.
  - When it differs and counter = DEBOUNCE_CYCLES-1: `level` takes the new value and the counter is cleared.
  - Net effect: a run shorter than DEBOUNCE_CYCLES is rejected. A run of exactly DEBOUNCE_CYCLES is accepted.
- **pulse:** registered, and goes high in the same cycle that `level` changes, provided the transition matches EDGE_MODE. It is high for exactly one cycle.
- **Auto-repeat FSM** per channel, with states IDLE, HOLD, REPEAT and a hold counter of width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - IDLE → HOLD: on the cycle `level` rises, provided REPEAT_DELAY > 0. The hold counter loads 1.
  - HOLD: the counter increments each cycle. When it equals REPEAT_DELAY, `rpt` fires, the counter loads 1 and the FSM goes to REPEAT.
  - REPEAT: the counter increments each cycle. When it equals REPEAT_PERIOD, `rpt` fires and the counter loads 1.
  - Any state → IDLE: the cycle `level` falls. The counter clears and no `rpt` is produced in that cycle or afterwards. A fall takes priority over a coincident repeat.
  - REPEAT_DELAY = 0: the FSM stays in IDLE permanently and `rpt` is constant 0.
- `rpt` is independent of EDGE_MODE. It is generated only while `level` = 1.

## Timing
- Reset, while rst_n = 0 at a clock edge:
  - all synchroniser flops, `level`, `pulse`, `rpt` and all counters go to 0;
  - the FSM goes to IDLE.
  - Outputs are 0 from the first edge at which rst_n is sampled low.
- Input latency: count the edge that first samples a new `sig` value as edge 1. `level` and `pulse` change at edge SYNC_STAGES+DEBOUNCE_CYCLES, so defaults give edge 6.
- Repeat timing, with `level` rising at edge R: `rpt` fires at R+REPEAT_DELAY, then at R+REPEAT_DELAY+k·REPEAT_PERIOD for k = 1, 2, … until `level` falls.
- Reset mid-operation: all state is discarded. If an input is still asserted after reset, it is re-accepted SYNC_STAGES+DEBOUNCE_CYCLES edges after rst_n returns high. That re-acceptance produces a fresh rise `pulse` and restarts the repeat schedule.
- Outputs are registered. There are no combinational paths from `sig` to any output.

## Test plan
All scenarios use N=2 and default parameters unless stated.
- **Reset:** hold rst_n=0 for 5 cycles while toggling sig every cycle -> level, pulse and rpt are 0 throughout and on the first edge after release.
- **Clean press:** sig[0] goes 0→1 and is first sampled at edge 1 -> level[0]=1 from edge 6; pulse[0] is high at edge 6 only; channel 1 does not change.
- **Glitch reject and boundary:** sig[1] high for 3 cycles -> no level, pulse or rpt activity. sig[1] high for exactly 4 cycles -> level[1] rises at edge 6, then falls 6 edges after the low value is first sampled.
- **Auto-repeat and release:** press sig[0] so that level rises at edge 6, then release with low first sampled at edge 31 -> rpt[0] fires at edges 16, 19, 22, 25, 28, 31, 34; level falls at edge 36; no rpt at or after edge 36. With EDGE_MODE=2, pulse[0] is also high at edge 36.
- **Simultaneous channels:** sig[0] and sig[1] rise together -> both levels and both pulses assert on the same edge, and the two rpt trains are cycle-aligned. Releasing only one channel stops only that channel's rpt.
- **Reset mid-hold:** rst_n=0 for one edge coincident with an rpt while sig[0] stays high -> outputs are 0 the next cycle; level[0] rises and pulse[0] fires 6 edges after rst_n is first sampled high; first rpt follows 10 edges later. With ACTIVE_LOW=1 the whole scenario is repeated with inverted stimulus and gives the same responses.
